// File: rtl/coremesh_sram_arb_ctrl.sv
// N-initiator Wishbone target ports arbitrated round-robin onto one byte-enabled
// single-port SRAM, with address-window decode (error on miss) and abort handling.
module coremesh_sram_arb_ctrl #(
    parameter int unsigned N_INITIATORS   = 4,
    parameter int unsigned ADR_WIDTH      = 32,
    parameter int unsigned DAT_WIDTH      = 32,
    parameter int unsigned SRAM_ADR_WIDTH = 20,
    parameter logic [ADR_WIDTH-1:0] WIN_BASE = 32'h8000_0000,
    parameter logic [ADR_WIDTH-1:0] WIN_MASK = 32'hFFC0_0000,
    localparam int unsigned BE_WIDTH = DAT_WIDTH / 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [N_INITIATORS*ADR_WIDTH-1:0] adr,
    input  logic [N_INITIATORS*DAT_WIDTH-1:0] dat_w,
    output logic [N_INITIATORS*DAT_WIDTH-1:0] dat_r,
    input  logic [N_INITIATORS-1:0]           cyc,
    input  logic [N_INITIATORS-1:0]           stb,
    input  logic [N_INITIATORS-1:0]           we,
    input  logic [N_INITIATORS*BE_WIDTH-1:0]  sel,
    output logic [N_INITIATORS-1:0]           ack,
    output logic [N_INITIATORS-1:0]           err,
    output logic [SRAM_ADR_WIDTH-1:0]         sram_addr,
    output logic [DAT_WIDTH-1:0]              sram_write_data,
    input  logic [DAT_WIDTH-1:0]              sram_read_data,
    output logic                              sram_read_en,
    output logic                              sram_write_en,
    output logic [BE_WIDTH-1:0]               sram_byte_en
);

    localparam int unsigned OFF = $clog2(BE_WIDTH);
    localparam int unsigned PW  = (N_INITIATORS > 1) ? $clog2(N_INITIATORS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e                            state_q;
    logic [PW-1:0]                     rr_ptr_q;
    logic [PW-1:0]                     g_q;
    logic                              we_q;
    logic                              hit_q;
    logic [N_INITIATORS-1:0]           ack_q;
    logic [N_INITIATORS-1:0]           err_q;
    logic [N_INITIATORS*DAT_WIDTH-1:0] dat_r_q;
    logic [SRAM_ADR_WIDTH-1:0]         sram_addr_q;
    logic [DAT_WIDTH-1:0]              sram_wdata_q;
    logic [BE_WIDTH-1:0]               sram_be_q;
    logic                              sram_rd_q;
    logic                              sram_wr_q;

    logic [N_INITIATORS-1:0] req;
    logic                    gnt_valid;
    logic [PW-1:0]           gnt_idx;
    logic [ADR_WIDTH-1:0]    gnt_adr;
    logic [DAT_WIDTH-1:0]    gnt_dat;
    logic [BE_WIDTH-1:0]     gnt_sel;
    logic                    gnt_we;
    logic                    gnt_hit;
    int unsigned             pos;

    assign req = cyc & stb;

    // Scan from rr_ptr upwards with wrap; the first requester wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        pos       = 0;
        for (int unsigned k = 0; k < N_INITIATORS; k++) begin
            pos = 32'(rr_ptr_q) + k;
            if (pos >= N_INITIATORS) pos = pos - N_INITIATORS;
            if (!gnt_valid && req[pos]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PW'(pos);
            end
        end
    end

    always_comb begin
        gnt_adr = adr[32'(gnt_idx)*ADR_WIDTH +: ADR_WIDTH];
        gnt_dat = dat_w[32'(gnt_idx)*DAT_WIDTH +: DAT_WIDTH];
        gnt_sel = sel[32'(gnt_idx)*BE_WIDTH +: BE_WIDTH];
        gnt_we  = we[gnt_idx];
        gnt_hit = ((gnt_adr & WIN_MASK) == WIN_BASE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            g_q          <= '0;
            we_q         <= 1'b0;
            hit_q        <= 1'b0;
            ack_q        <= '0;
            err_q        <= '0;
            dat_r_q      <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_be_q    <= '0;
            sram_rd_q    <= 1'b0;
            sram_wr_q    <= 1'b0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        g_q      <= gnt_idx;
                        we_q     <= gnt_we;
                        hit_q    <= gnt_hit;
                        rr_ptr_q <= (32'(gnt_idx) == N_INITIATORS - 1) ? '0 : gnt_idx + 1'b1;
                        state_q  <= ACCESS;
                        // Strobes are registered here so they are valid throughout ACCESS.
                        if (gnt_hit) begin
                            sram_addr_q  <= gnt_adr[SRAM_ADR_WIDTH+OFF-1:OFF];
                            sram_wdata_q <= gnt_dat;
                            sram_be_q    <= gnt_sel;
                            sram_rd_q    <= !gnt_we;
                            sram_wr_q    <= gnt_we;
                        end
                    end
                end
                ACCESS: begin
                    sram_addr_q  <= '0;
                    sram_wdata_q <= '0;
                    sram_be_q    <= '0;
                    sram_rd_q    <= 1'b0;
                    sram_wr_q    <= 1'b0;
                    if (cyc[g_q]) begin
                        if (hit_q) ack_q[g_q] <= 1'b1;
                        else       err_q[g_q] <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (hit_q && !we_q)
                        dat_r_q[32'(g_q)*DAT_WIDTH +: DAT_WIDTH] <= sram_read_data;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gating by cyc suppresses the response if the initiator drops cyc during RESP.
    assign ack = ack_q & cyc;
    assign err = err_q & cyc;

    // Read data arrives one cycle after read_en, i.e. during RESP; pass it straight through.
    always_comb begin
        dat_r = dat_r_q;
        if (state_q == RESP && hit_q && !we_q)
            dat_r[32'(g_q)*DAT_WIDTH +: DAT_WIDTH] = sram_read_data;
    end

    assign sram_addr       = sram_addr_q;
    assign sram_write_data = sram_wdata_q;
    assign sram_byte_en    = sram_be_q;
    assign sram_read_en    = sram_rd_q;
    assign sram_write_en   = sram_wr_q;

endmodule

// File: tb/tb_coremesh_sram_arb_ctrl.sv
// Bench for coremesh_sram_arb_ctrl: vector table plus hand sequences for abort,
// contention and mid-transaction reset; responses checked through a scoreboard queue.
module tb_coremesh_sram_arb_ctrl;
    localparam int N = 4, AW = 32, DW = 32, BW = 4, SAW = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [N*AW-1:0] adr;
    logic [N*DW-1:0] dat_w, dat_r;
    logic [N-1:0]    cyc, stb, we, ack, err;
    logic [N*BW-1:0] sel;
    logic [SAW-1:0]  sram_addr;
    logic [DW-1:0]   sram_write_data, sram_read_data;
    logic            sram_read_en, sram_write_en;
    logic [BW-1:0]   sram_byte_en;

    coremesh_sram_arb_ctrl #(
        .N_INITIATORS(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .SRAM_ADR_WIDTH(SAW),
        .WIN_BASE(32'h8000_0000), .WIN_MASK(32'hFFC0_0000)
    ) dut (
        .clock(clock), .reset(reset), .adr(adr), .dat_w(dat_w), .dat_r(dat_r),
        .cyc(cyc), .stb(stb), .we(we), .sel(sel), .ack(ack), .err(err),
        .sram_addr(sram_addr), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data), .sram_read_en(sram_read_en),
        .sram_write_en(sram_write_en), .sram_byte_en(sram_byte_en)
    );

    // SRAM model: one-cycle read latency, byte-enabled writes, backdoor load port.
    logic [31:0] mem [0:255];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_a  = '0;
    logic [31:0] ld_d  = '0;
    always @(posedge clock) begin
        if (ld_en) mem[ld_a] <= ld_d;
        if (sram_read_en) sram_read_data <= mem[sram_addr[7:0]];
        if (sram_write_en)
            for (int b = 0; b < BW; b++)
                if (sram_byte_en[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_write_data[b*8 +: 8];
    end

    typedef struct {
        int          idx;
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        exp_err;
        logic [19:0] exp_sa;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        int          idx;
        logic        is_err;
        logic        chk_data;
        logic [31:0] rd;
    } sb_t;

    sb_t  sb_q[$];
    sb_t  e;
    int   checks = 0, errors = 0;
    int   cycle_n = 0;
    int   last_resp = -1;
    logic gap_mode = 1'b0;
    logic [N-1:0] onehot;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clock) cycle_n++;

    // Scoreboard: every ack/err pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && (|ack || |err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 64'({ack, err}), 64'(0));
            end else begin
                e = sb_q.pop_front();
                onehot = '0;
                onehot[e.idx] = 1'b1;
                chk("ack_vec", 64'(ack), e.is_err ? 64'(0) : 64'(onehot));
                chk("err_vec", 64'(err), e.is_err ? 64'(onehot) : 64'(0));
                if (e.chk_data) chk("dat_r", 64'(dat_r[e.idx*DW +: DW]), 64'(e.rd));
                if (gap_mode && last_resp >= 0) chk("resp_gap", 64'(cycle_n - last_resp), 64'(3));
                last_resp = cycle_n;
            end
        end
    end

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        @(negedge clock);
        ld_en = 1'b1; ld_a = a; ld_d = d;
        @(posedge clock); #1;
        ld_en = 1'b0;
    endtask

    task automatic drive(input int i, input logic [31:0] a, input logic w,
                         input logic [3:0] s, input logic [31:0] d);
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w;
        adr[i*AW +: AW] = a; sel[i*BW +: BW] = s; dat_w[i*DW +: DW] = d;
    endtask

    task automatic release_all();
        cyc = '0; stb = '0; we = '0;
    endtask

    task automatic do_xfer(input vec_t v);
        @(negedge clock);
        drive(v.idx, v.adr, v.we, v.sel, v.wdat);
        sb_q.push_back('{v.idx, v.exp_err, !v.exp_err && !v.we, v.exp_rd});
        @(posedge clock); #1;
        chk("rd_en", 64'(sram_read_en), 64'(!v.exp_err && !v.we));
        chk("wr_en", 64'(sram_write_en), 64'(!v.exp_err && v.we));
        if (!v.exp_err) begin
            chk("sram_addr", 64'(sram_addr), 64'(v.exp_sa));
            chk("byte_en", 64'(sram_byte_en), 64'(v.sel));
            if (v.we) chk("wdata", 64'(sram_write_data), 64'(v.wdat));
        end
        @(posedge clock); #1;
        chk("resp_kind", 64'({|ack, |err}), v.exp_err ? 64'(2'b01) : 64'(2'b10));
        chk("strobes_resp", 64'({sram_read_en, sram_write_en}), 64'(0));
        @(posedge clock); #1;
        chk("pulse_end", 64'({ack, err}), 64'(0));
        release_all();
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 40 && sb_q.size() != 0; c++) begin
            @(negedge clock); #1;
        end
        chk(name, 64'(sb_q.size()), 64'(0));
        sb_q.delete();
        release_all();
    endtask

    initial begin
        vecs[0] = '{0, 32'h8000_0010, 1'b0, 4'hF, 32'h0,         1'b0, 20'h4,     32'hDEAD_BEEF};
        vecs[1] = '{2, 32'h8000_0008, 1'b1, 4'h4, 32'h00AB_0000, 1'b0, 20'h2,     32'h0};
        vecs[2] = '{2, 32'h8000_0008, 1'b0, 4'hF, 32'h0,         1'b0, 20'h2,     32'h11AB_3344};
        vecs[3] = '{1, 32'h9000_0000, 1'b0, 4'hF, 32'h0,         1'b1, 20'h0,     32'h0};
        vecs[4] = '{3, 32'h803F_FFFC, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 20'hFFFFF, 32'h0};
        vecs[5] = '{0, 32'h803F_FFFC, 1'b0, 4'hF, 32'h0,         1'b0, 20'hFFFFF, 32'hCAFE_F00D};
        vecs[6] = '{1, 32'h8040_0000, 1'b1, 4'hF, 32'h1111_1111, 1'b1, 20'h0,     32'h0};
        vecs[7] = '{3, 32'h7FFF_FFFC, 1'b0, 4'hF, 32'h0,         1'b1, 20'h0,     32'h0};
        vecs[8] = '{1, 32'h8000_0010, 1'b1, 4'h3, 32'h0000_5A5A, 1'b0, 20'h4,     32'h0};
        vecs[9] = '{1, 32'h8000_0010, 1'b0, 4'hF, 32'h0,         1'b0, 20'h4,     32'hDEAD_5A5A};

        adr = '0; dat_w = '0; sel = '0; release_all();
        #1;
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_strobes", 64'({sram_read_en, sram_write_en}), 64'(0));
        chk("rst_sram_addr", 64'(sram_addr), 64'(0));
        chk("rst_sram_be_wd", 64'({sram_byte_en, sram_write_data}), 64'(0));
        chk("rst_dat_r", dat_r[63:0], 64'(0));
        chk("rst_dat_r_hi", dat_r[127:64], 64'(0));
        load(8'h04, 32'hDEAD_BEEF);
        load(8'h02, 32'h1122_3344);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) do_xfer(vecs[i]);
        chk("mem_word2", 64'(mem[2]), 64'(32'h11AB_3344));

        // Abort: write issued, cyc dropped in ACCESS -> write lands, no ack.
        @(negedge clock);
        drive(3, 32'h8000_0020, 1'b1, 4'hF, 32'h1234_5678);
        @(posedge clock); #1;
        chk("abort_wr_en", 64'(sram_write_en), 64'(1));
        chk("abort_addr", 64'(sram_addr), 64'(8));
        release_all();
        @(posedge clock); #1;
        chk("abort_no_resp", 64'({ack, err}), 64'(0));
        chk("abort_strobe_off", 64'(sram_write_en), 64'(0));
        @(posedge clock);
        do_xfer('{0, 32'h8000_0020, 1'b0, 4'hF, 32'h0, 1'b0, 20'h8, 32'h1234_5678});

        // Contention: all initiators request from reset -> 0,1,2,3,0,1,2,3 every 3 cycles.
        for (int i = 0; i < N; i++) load(8'(i), 32'hC0DE_0000 | 32'(i));
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < N; i++) drive(i, 32'h8000_0000 + 32'(4*i), 1'b0, 4'hF, 32'h0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) sb_q.push_back('{i, 1'b0, 1'b1, 32'hC0DE_0000 | 32'(i)});
        gap_mode = 1'b1; last_resp = -1;
        @(negedge clock);
        reset = 1'b0;
        drain("contention_done");
        gap_mode = 1'b0;
        repeat (3) @(negedge clock);

        // Reset during RESP of a read, then rr_ptr must restart at 0.
        @(negedge clock);
        drive(1, 32'h8000_0004, 1'b0, 4'hF, 32'h0);
        @(posedge clock); #1;
        chk("mid_rd_en", 64'(sram_read_en), 64'(1));
        @(posedge clock); #1;
        chk("pre_reset_ack", 64'(ack), 64'(4'b0010));
        reset = 1'b1;
        #1;
        chk("reset_ack", 64'({ack, err}), 64'(0));
        chk("reset_strobes", 64'({sram_read_en, sram_write_en}), 64'(0));
        chk("reset_dat_r", dat_r[63:0], 64'(0));
        drive(3, 32'h8000_000C, 1'b0, 4'hF, 32'h0);
        sb_q.push_back('{1, 1'b0, 1'b1, 32'hC0DE_0001});
        sb_q.push_back('{3, 1'b0, 1'b1, 32'hC0DE_0003});
        @(negedge clock);
        reset = 1'b0;
        drain("post_reset_done");
        repeat (4) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/coremesh_sram_arb_ctrl.md
Name: coremesh_sram_arb_ctrl

Overview:
Parametrised N-initiator Wishbone-to-single-port-SRAM controller for coremesh clusters. It merges the interconnect and SRAM-controller roles into one block. Each initiator gets a dedicated Wishbone target port; a fair round-robin arbiter serialises requests onto one byte-enabled SRAM port. Unlike a fixed single-port controller, it adds address-window decode with error response and abort handling.

Parameters:
N_INITIATORS, 4, number of Wishbone target ports (1..16)
ADR_WIDTH, 32, Wishbone byte-address width
DAT_WIDTH, 32, data width (32 or 64); BE_WIDTH = DAT_WIDTH/8
SRAM_ADR_WIDTH, 20, SRAM word-address width
WIN_BASE, 32'h8000_0000, decoded window base
WIN_MASK, 32'hFFC0_0000, window mask; hit when (adr & WIN_MASK) == WIN_BASE

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
adr  in  N_INITIATORS*ADR_WIDTH  per-initiator byte address, initiator i at slice i
dat_w  in  N_INITIATORS*DAT_WIDTH  per-initiator write data
dat_r  out  N_INITIATORS*DAT_WIDTH  per-initiator read data
cyc  in  N_INITIATORS  bus cycle
stb  in  N_INITIATORS  strobe
we  in  N_INITIATORS  write enable
sel  in  N_INITIATORS*BE_WIDTH  byte selects
ack  out  N_INITIATORS  transfer acknowledge
err  out  N_INITIATORS  error acknowledge
sram_addr  out  SRAM_ADR_WIDTH  word address = adr[SRAM_ADR_WIDTH+log2(BE_WIDTH)-1 : log2(BE_WIDTH)]
sram_write_data  out  DAT_WIDTH  write data
sram_read_data  in  DAT_WIDTH  read data, valid one cycle after read_en
sram_read_en  out  1  read strobe
sram_write_en  out  1  write strobe
sram_byte_en  out  BE_WIDTH  byte enables (= sel)

Behaviour:
- Reset: FSM=IDLE, rr_ptr=0, ack=0, err=0, all sram_* outputs 0, dat_r=0.
- Request from i = cyc[i] & stb[i].
- Arbitration in IDLE: first requesting index scanning rr_ptr, rr_ptr+1, ... mod N. Winner g, its adr/dat_w/we/sel and window hit are latched. rr_ptr <= (g+1) mod N on grant.
- States:
  - IDLE -> ACCESS when any request is present.
  - ACCESS (1 cycle): on hit, sram_addr/byte_en/write_data are driven from the latch, and read_en=!we or write_en=we. On miss, no SRAM strobes. -> RESP.
  - RESP (1 cycle): on hit, ack[g]=1; on miss, err[g]=1. For a hit read, dat_r slice g = sram_read_data. -> IDLE.
- Latency: stb seen at edge N; SRAM strobes during cycle N+1; ack/err during cycle N+2. Throughput is one transfer per 3 cycles.
- ack/err are single-cycle pulses, never both, and only to g. All other ack/err stay 0.
- SRAM strobes are exclusive and asserted only in ACCESS; they are 0 in IDLE/RESP.
- dat_r slices other than g hold their last value; contents matter only when ack=1.
- Abort: if cyc[g] drops in ACCESS or RESP, the SRAM access (already issued) completes. The ack/err pulse is suppressed, and the FSM returns to IDLE normally.
- Initiators holding stb after ack are re-arbitrated as new requests and wait their round-robin turn.
- Simultaneous requests from all initiators: each is served exactly once per N transfers (no starvation).
- N_INITIATORS=1: rr_ptr is a constant 0; behaviour is otherwise identical.
- Reset mid-transaction: immediate return to the reset state. An in-flight access is dropped with no ack/err.

Test Plan:
- Single read hit: init 0 reads 0x8000_0010 with SRAM word 4=0xDEADBEEF -> read_en in cycle N+1 with sram_addr=4; ack[0] and dat_r[0]=0xDEADBEEF in cycle N+2.
- Byte write: init 2 writes 0x8000_0008, sel=4'b0100, dat_w=0x00AB0000 -> write_en=1, byte_en=0100, sram_addr=2; ack[2] 2 cycles later; word 2 byte 2 = 0xAB, other bytes unchanged.
- Out-of-window: init 1 reads 0x9000_0000 -> no SRAM strobe; err[1]=1 for one cycle; ack=0.
- Contention: all 4 initiators request continuously from reset -> grants in order 0,1,2,3,0,... with acks every 3 cycles and no index skipped.
- Abort: init 3 writes, then drops cyc in ACCESS -> write_en still pulses, ack[3] stays 0, FSM in IDLE next cycle.
- Reset mid-op: assert reset during RESP of a read -> ack/err/strobes go to 0 immediately; after release, the first grant goes to the lowest requesting index (rr_ptr=0).
